// File: rtl/second_countdown_timer.sv
// mm:ss countdown timer in the clk_2MHz domain, decremented once per rising edge of an
// asynchronous 1 Hz square wave. Expiry raises a flag plus a registered one-cycle done pulse.
module second_countdown_timer #(
  parameter int unsigned MAX_MIN = 99,
  parameter int unsigned MIN_W   = 7
) (
  input  logic             clk_2MHz,
  input  logic             reset,
  input  logic             clk_1Hz,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             start_stop,
  output logic [MIN_W-1:0] min_out,
  output logic [5:0]       sec_out,
  output logic             running,
  output logic             expired,
  output logic             done_pulse
);

  localparam logic [MIN_W-1:0] MaxMin = MIN_W'(MAX_MIN);
  localparam logic [5:0]       MaxSec = 6'd59;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             done_q, done_d;
  logic             s1_q, s2_q, s3_q;
  logic             tick;
  logic             count_zero;
  logic [MIN_W-1:0] dec_min;
  logic [5:0]       dec_sec;
  logic             dec_zero;

  // clk_1Hz is asynchronous: two-flop synchroniser, then a delay flop for edge detection.
  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_1Hz;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  always_ff @(posedge clk_2MHz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      min_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign count_zero = (min_q == '0) && (sec_q == '0);

  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q != '0) begin
      dec_sec = sec_q - 6'd1;
    end else if (min_q != '0) begin
      dec_sec = MaxSec;
      dec_min = min_q - MIN_W'(1);
    end
  end

  assign dec_zero = (dec_min == '0) && (dec_sec == '0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    if (load) begin
      // Load overrides any coincident tick or start_stop.
      state_d = StIdle;
      min_d   = (load_min > MaxMin) ? MaxMin : load_min;
      sec_d   = (load_sec > MaxSec) ? MaxSec : load_sec;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_stop && !count_zero) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            min_d = dec_min;
            sec_d = dec_sec;
          end
          // Reaching 00:00 wins over a coincident pause request.
          if (tick && dec_zero) begin
            state_d = StExpired;
            done_d  = 1'b1;
          end else if (start_stop) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (start_stop) state_d = StRun;
        end
        StExpired: begin
          if (start_stop) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    min_out    = min_q;
    sec_out    = sec_q;
    running    = (state_q == StRun);
    expired    = (state_q == StExpired);
    done_pulse = done_q;
  end

endmodule

// File: tb/tb_second_countdown_timer.sv
// Bench for second_countdown_timer: directed scenarios plus random stimulus checked against a
// total-seconds reference model.
`timescale 1ns/1ps
module tb_second_countdown_timer;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MPause = 2;
  localparam int MExp  = 3;

  logic       clk_2MHz = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic       start_stop = 1'b0;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running;
  logic       expired;
  logic       done_pulse;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int due_q[$];
  int m_secs = 0;
  int m_st = MIdle;
  bit m_done = 1'b0;

  second_countdown_timer dut (
    .clk_2MHz  (clk_2MHz),
    .reset     (reset),
    .clk_1Hz   (clk_1Hz),
    .load      (load),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .start_stop(start_stop),
    .min_out   (min_out),
    .sec_out   (sec_out),
    .running   (running),
    .expired   (expired),
    .done_pulse(done_pulse)
  );

  always #250 clk_2MHz = ~clk_2MHz;

  function automatic logic [15:0] model_vec();
    return {7'(m_secs / 60), 6'(m_secs % 60), m_st == MRun, m_st == MExp, m_done};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {min_out, sec_out, running, expired, done_pulse};
  endfunction

  function automatic void model_reset();
    m_secs = 0;
    m_st   = MIdle;
    m_done = 1'b0;
    due_q.delete();
  endfunction

  // One clock cycle, entered and left at a falling edge. lvl: -1 hold clk_1Hz, else drive it.
  // A rising edge of clk_1Hz takes effect on the count at the third following clock edge.
  task automatic step(input bit ld, input int lmin, input int lsec, input bit ss, input int lvl);
    bit tk;
    load       = ld;
    load_min   = 7'(lmin);
    load_sec   = 6'(lsec);
    start_stop = ss;
    if (lvl == 1 && clk_1Hz == 1'b0) due_q.push_back(cyc + 3);
    if (lvl >= 0) clk_1Hz = (lvl != 0);
    @(posedge clk_2MHz);
    cyc++;
    tk = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      tk = 1'b1;
      void'(due_q.pop_front());
    end
    m_done = 1'b0;
    if (ld) begin
      m_secs = ((lmin > 99) ? 99 : lmin) * 60 + ((lsec > 59) ? 59 : lsec);
      m_st   = MIdle;
    end else begin
      case (m_st)
        MIdle:  if (ss && m_secs != 0) m_st = MRun;
        MRun: begin
          if (tk) m_secs = m_secs - 1;
          if (tk && m_secs == 0) begin
            m_st   = MExp;
            m_done = 1'b1;
          end else if (ss) begin
            m_st = MPause;
          end
        end
        MPause: if (ss) m_st = MRun;
        default: if (ss) m_st = MIdle;
      endcase
    end
    @(negedge clk_2MHz);
    load       = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, -1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_2MHz);
    tests++;
    if (dut_vec() !== 16'h0) begin
      fails++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(), 16'h0);
    end
    reset = 1'b0;
    model_reset();
    idle(2);
    tests++;
    if (dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL reset_release got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_countdown();
    step(1, 0, 3, 0, -1);
    step(0, 0, 0, 1, -1);
    tests++;
    if (dut_vec() !== model_vec() || running !== 1'b1) begin
      fails++;
      $display("FAIL cd_start got=%h want=%h", dut_vec(), model_vec());
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, -1);
      tests++;
      if (sec_out !== 6'(3 - k) || dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL cd_early%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
      step(0, 0, 0, 0, -1);
      tests++;
      if (sec_out !== 6'(2 - k) || dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL cd_tick%0d got=%h want=%h", k, dut_vec(), model_vec());
      end
      step(0, 0, 0, 0, 0);
      tests++;
      if (done_pulse !== 1'b0) begin
        fails++;
        $display("FAIL cd_done_width%0d got=%b want=0", k, done_pulse);
      end
      step(0, 0, 0, 0, -1);
    end
    tests++;
    if (expired !== 1'b1 || running !== 1'b0 || dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL cd_expired got=%h want=%h", dut_vec(), model_vec());
    end
    step(0, 0, 0, 1, -1);
    tests++;
    if (expired !== 1'b0 || {min_out, sec_out} !== 13'h0) begin
      fails++;
      $display("FAIL cd_ack got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic one_second();
    step(0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, -1);
  endtask

  task automatic test_borrow();
    step(1, 2, 0, 0, -1);
    step(0, 0, 0, 1, -1);
    one_second();
    tests++;
    if (min_out !== 7'd1 || sec_out !== 6'd59) begin
      fails++;
      $display("FAIL borrow got=%0d:%0d want=1:59", min_out, sec_out);
    end
    one_second();
    tests++;
    if (min_out !== 7'd1 || sec_out !== 6'd58 || dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL borrow2 got=%0d:%0d want=1:58", min_out, sec_out);
    end
  endtask

  task automatic test_pause();
    step(1, 1, 30, 0, -1);
    step(0, 0, 0, 1, -1);
    repeat (2) one_second();
    step(0, 0, 0, 1, -1);
    repeat (5) one_second();
    tests++;
    if (min_out !== 7'd1 || sec_out !== 6'd28 || running !== 1'b0) begin
      fails++;
      $display("FAIL pause_hold got=%h want=%h", dut_vec(), model_vec());
    end
    step(0, 0, 0, 1, -1);
    one_second();
    tests++;
    if (min_out !== 7'd1 || sec_out !== 6'd27 || running !== 1'b1) begin
      fails++;
      $display("FAIL pause_resume got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_load_clamp();
    step(1, 120, 63, 0, -1);
    tests++;
    if (min_out !== 7'd99 || sec_out !== 6'd59 || running !== 1'b0 || expired !== 1'b0) begin
      fails++;
      $display("FAIL clamp got=%h want=%h", dut_vec(), model_vec());
    end
    step(1, 0, 0, 0, -1);
    step(0, 0, 0, 1, -1);
    idle(1);
    tests++;
    if (dut_vec() !== 16'h0) begin
      fails++;
      $display("FAIL zero_start got=%h want=%h", dut_vec(), 16'h0);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 10, 0, -1);
    step(0, 0, 0, 1, -1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, -1);
    step(1, 0, 5, 0, 0);
    tests++;
    if (min_out !== 7'd0 || sec_out !== 6'd5 || running !== 1'b0) begin
      fails++;
      $display("FAIL load_vs_tick got=%h want=%h", dut_vec(), model_vec());
    end
    step(1, 0, 1, 0, -1);
    step(0, 0, 0, 1, -1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, -1);
    step(0, 0, 0, 1, 0);
    tests++;
    if (dut_vec() !== 16'h0003 || dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL ss_vs_tick got=%h want=%h", dut_vec(), 16'h0003);
    end
    idle(1);
    tests++;
    if (done_pulse !== 1'b0 || expired !== 1'b1) begin
      fails++;
      $display("FAIL ss_vs_tick_after got=%h want=%h", dut_vec(), 16'h0002);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1, 5, 0, 0, 0);
    step(0, 0, 0, 1, -1);
    idle(4);
    @(posedge clk_2MHz);
    #100 reset = 1'b1;
    #1;
    tests++;
    if (dut_vec() !== 16'h0) begin
      fails++;
      $display("FAIL async_reset got=%h want=%h", dut_vec(), 16'h0);
    end
    clk_1Hz = 1'b1;
    repeat (2) @(negedge clk_2MHz);
    reset = 1'b0;
    model_reset();
    idle(5);
    step(1, 0, 5, 0, -1);
    step(0, 0, 0, 1, -1);
    idle(8);
    tests++;
    if (sec_out !== 6'd5 || running !== 1'b1 || dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL no_spurious_tick got=%h want=%h", dut_vec(), model_vec());
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    tests++;
    if (sec_out !== 6'd4 || dut_vec() !== model_vec()) begin
      fails++;
      $display("FAIL first_tick_after_reset got=%h want=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      bit ld;
      bit ss;
      int lmin;
      int lsec;
      int lvl;
      ld   = ($urandom_range(0, 19) == 0);
      lmin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 1);
      lsec = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4);
      ss   = ($urandom_range(0, 5) == 0);
      lvl  = -1;
      if (hold >= 2 && $urandom_range(0, 1) == 1) begin
        lvl  = clk_1Hz ? 0 : 1;
        hold = 0;
      end else begin
        hold++;
      end
      step(ld, lmin, lsec, ss, lvl);
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL random%0d got=%h want=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_load_clamp();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
